// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict detection and branch statistics
`ifndef XLEN
`define XLEN 32
`endif
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`XLEN-1:0]  fetch_pc,
    output logic              pred_taken,
    output logic [`XLEN-1:0]  pred_target,
    input  logic              upd_valid,
    input  logic [`XLEN-1:0]  upd_pc,
    input  logic              upd_taken,
    input  logic [`XLEN-1:0]  upd_target,
    input  logic              upd_pred_taken,
    input  logic [`XLEN-1:0]  upd_pred_target,
    output logic              mispredict,
    output logic [`XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);
    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W = `XLEN - IDX_BITS - 2;
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [`XLEN-1:0]   tgt_mem [ENTRIES];
    logic [1:0]         cnt_mem [ENTRIES];
    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]    f_tag, u_tag;
    logic                f_hit, u_hit;
    logic [1:0]          u_cnt, u_cnt_next;
    always_comb begin
        f_idx = fetch_pc[IDX_BITS+1:2];
        f_tag = fetch_pc[`XLEN-1:IDX_BITS+2];
        f_hit = valid[f_idx] && tag_mem[f_idx] == f_tag;
        pred_taken = f_hit && cnt_mem[f_idx][1];
        pred_target = pred_taken ? tgt_mem[f_idx] : fetch_pc + `XLEN'(4);
        u_idx = upd_pc[IDX_BITS+1:2];
        u_tag = upd_pc[`XLEN-1:IDX_BITS+2];
        u_hit = valid[u_idx] && tag_mem[u_idx] == u_tag;
        u_cnt = cnt_mem[u_idx];
        u_cnt_next = !u_hit ? 2'd2
                   : upd_taken ? (u_cnt == 2'd3 ? u_cnt : u_cnt + 2'd1)
                   : (u_cnt == 2'd0 ? u_cnt : u_cnt - 2'd1);
        mispredict = upd_valid && (upd_taken != upd_pred_taken ||
                     (upd_taken && upd_target != upd_pred_target));
        redirect_pc = upd_taken ? upd_target : upd_pc + `XLEN'(4);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_mem[i] <= 2'd1;
            branch_count <= '0;
            mispredict_count <= '0;
        end else if (upd_valid) begin
            if (u_hit || upd_taken) cnt_mem[u_idx] <= u_cnt_next;
            if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                tag_mem[u_idx] <= u_tag;
                tgt_mem[u_idx] <= upd_target;
            end
            branch_count <= &branch_count ? branch_count : branch_count + CNT_W'(1);
            if (mispredict && !(&mispredict_count)) mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus randomized run against a BTB reference model
`ifndef XLEN
`define XLEN 32
`endif
module tb_branch_predictor;
    localparam int IDX_BITS = 4;
    localparam int CNT_W = 6;
    localparam int ENT = 1 << IDX_BITS;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] fetch_pc, upd_pc, upd_target, upd_pred_target, pred_target, redirect_pc;
    logic upd_valid, upd_taken, upd_pred_taken, pred_taken, mispredict;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r;
        logic [31:0] f;
        bit uv;
        logic [31:0] up;
        bit ut;
        logic [31:0] utg;
        bit upt;
        logic [31:0] uptg;
        bit ept;
        logic [31:0] etg;
        bit emp;
        logic [31:0] erd;
        int ebc;
        int emc;
    } vec_t;

    vec_t vecs[$];

    // reference model: one slot per index, remembering the full word address of the owner
    bit          m_valid [ENT];
    logic [29:0] m_line [ENT];
    logic [31:0] m_tgt [ENT];
    int          m_cnt [ENT];
    int          m_bc, m_mc;

    function automatic vec_t mk(bit r, logic [31:0] f, bit uv, logic [31:0] up, bit ut,
                                logic [31:0] utg, bit upt, logic [31:0] uptg, bit ept,
                                logic [31:0] etg, bit emp, logic [31:0] erd, int ebc, int emc);
        vec_t v;
        v.r = r; v.f = f; v.uv = uv; v.up = up; v.ut = ut; v.utg = utg; v.upt = upt;
        v.uptg = uptg; v.ept = ept; v.etg = etg; v.emp = emp; v.erd = erd; v.ebc = ebc; v.emc = emc;
        return v;
    endfunction

    function automatic vec_t idle(logic [31:0] f, bit ept, logic [31:0] etg, int ebc, int emc);
        return mk(0, f, 0, 0, 0, 0, 0, 0, ept, etg, 0, 32'h4, ebc, emc);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.r; fetch_pc = v.f; upd_valid = v.uv; upd_pc = v.up; upd_taken = v.ut;
        upd_target = v.utg; upd_pred_taken = v.upt; upd_pred_target = v.uptg;
    endtask

    function automatic int slot(logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && m_line[slot(pc)] == pc[31:2];
    endfunction

    function automatic bit m_pt(logic [31:0] pc);
        return m_hit(pc) && m_cnt[slot(pc)] >= 2;
    endfunction

    function automatic logic [31:0] m_ptg(logic [31:0] pc);
        return m_pt(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_cnt[i] = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_update(logic [31:0] pc, bit t, logic [31:0] tg, bit mp);
        int s;
        s = slot(pc);
        if (m_hit(pc)) begin
            if (t) begin
                m_cnt[s] = m_cnt[s] < 3 ? m_cnt[s] + 1 : 3;
                m_tgt[s] = tg;
            end else m_cnt[s] = m_cnt[s] > 0 ? m_cnt[s] - 1 : 0;
        end else if (t) begin
            m_valid[s] = 1;
            m_line[s] = pc[31:2];
            m_tgt[s] = tg;
            m_cnt[s] = 2;
        end
        m_bc = m_bc < CMAX ? m_bc + 1 : CMAX;
        if (mp) m_mc = m_mc < CMAX ? m_mc + 1 : CMAX;
    endtask

    initial begin
        vec_t v;
        logic [31:0] fpc, upc, utg, uptg;
        bit r, uv, ut, upt, emp;

        vecs.push_back(idle(32'h100, 0, 32'h104, 0, 0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 0, 0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80, 1, 1));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80, 2, 1));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104, 3, 1));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104, 4, 2));
        vecs.push_back(idle(32'h100, 0, 32'h104, 5, 3));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 5, 3));
        vecs.push_back(mk(0, 32'h100, 1, 32'h140, 1, 32'h500, 0, 32'h144, 1, 32'h80, 1, 32'h500, 6, 4));
        vecs.push_back(idle(32'h100, 0, 32'h104, 7, 5));
        vecs.push_back(idle(32'h140, 1, 32'h500, 7, 5));
        vecs.push_back(mk(0, 32'h200, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 7, 5));
        vecs.push_back(mk(0, 32'h200, 1, 32'h200, 1, 32'h340, 1, 32'h300, 1, 32'h300, 1, 32'h340, 8, 6));
        vecs.push_back(idle(32'h200, 1, 32'h340, 9, 7));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 0, 0));
        vecs.push_back(idle(32'h100, 0, 32'h104, 0, 0));
        vecs.push_back(idle(32'h200, 0, 32'h204, 0, 0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h180, 0, 32'h900, 1, 32'h900, 0, 32'h104, 1, 32'h184, 0, 0));
        vecs.push_back(idle(32'h180, 0, 32'h184, 1, 1));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 1, 1));
        vecs.push_back(idle(32'h100, 1, 32'h80, 2, 2));
        vecs.push_back(idle(32'hFFFF_FFFC, 0, 32'h0, 2, 2));

        drive(idle(32'h100, 0, 32'h104, 0, 0));
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            @(negedge clk);
            chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(v.emp));
            chk($sformatf("v%0d redirect_pc", i), redirect_pc, v.erd);
            if (!v.r) begin
                chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(v.ept));
                chk($sformatf("v%0d pred_target", i), pred_target, v.etg);
                chk($sformatf("v%0d branch_count", i), 32'(branch_count), v.ebc);
                chk($sformatf("v%0d mispredict_count", i), 32'(mispredict_count), v.emc);
            end
            @(posedge clk);
            #1;
        end

        rst = 1;
        upd_valid = 0;
        @(posedge clk);
        #1;
        m_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 59) == 0;
            fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) upc = upc | 32'hFFFF_0000;
            uv = $urandom_range(0, 3) != 0;
            ut = $urandom_range(0, 1);
            utg = $urandom_range(0, 7) << 4;
            if ($urandom_range(0, 3) != 0) begin
                upt = m_pt(upc);
                uptg = m_ptg(upc);
            end else begin
                upt = $urandom_range(0, 1);
                uptg = $urandom_range(0, 7) << 4;
            end
            rst = r; fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
            upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
            emp = uv && (ut != upt || (ut && utg != uptg));
            @(negedge clk);
            chk("rand mispredict", 32'(mispredict), 32'(emp));
            chk("rand redirect_pc", redirect_pc, ut ? utg : upc + 32'd4);
            if (!r) begin
                chk("rand pred_taken", 32'(pred_taken), 32'(m_pt(fpc)));
                chk("rand pred_target", pred_target, m_ptg(fpc));
                chk("rand branch_count", 32'(branch_count), m_bc);
                chk("rand mispredict_count", 32'(mispredict_count), m_mc);
            end
            @(posedge clk);
            if (r) m_reset();
            else if (uv) m_update(upc, ut, utg, emp);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the 3-stage RISC-V core.
- A direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Supplies a predicted next PC for the fetch PC each cycle.
- Trained by the execute-stage branch resolution outcome (taken flag, target); flags mispredicts so the core can flush and redirect.

Parameters:
- IDX_BITS, 4, log2 of BTB entry count (ENTRIES = 2**IDX_BITS, valid 2..8)
- CNT_W, 32, width of branch and mispredict statistics counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  `XLEN  PC being fetched this cycle
- pred_taken  out  1  prediction for fetch_pc is taken
- pred_target  out  `XLEN  predicted next PC
- upd_valid  in  1  a resolved conditional branch is in execute this cycle
- upd_pc  in  `XLEN  PC of the resolved branch
- upd_taken  in  1  resolved outcome (PCSel branch bit from execute)
- upd_target  in  `XLEN  resolved branch target (PC + B-immediate)
- upd_pred_taken  in  1  pred_taken carried down the pipe with this branch
- upd_pred_target  in  `XLEN  pred_target carried down the pipe with this branch
- mispredict  out  1  resolved branch was mispredicted; flush and redirect
- redirect_pc  out  `XLEN  correct next PC when mispredict=1
- branch_count  out  CNT_W  resolved branches since reset
- mispredict_count  out  CNT_W  mispredicts since reset

Behaviour:
- Address split: index = pc[IDX_BITS+1:2], tag = pc[`XLEN-1:IDX_BITS+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target (`XLEN), cnt (2 bits).
  - Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- Prediction, purely combinational, zero latency:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[1].
  - pred_target = target when pred_taken, else fetch_pc + 4 (mod 2^XLEN).
- Update, registered, when upd_valid=1 at the clock edge:
  - Hit and taken: cnt = min(cnt+1, 3); target <= upd_target.
  - Hit and not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss and taken: allocate/replace the entry (valid=1, tag, target=upd_target, cnt=2).
  - Miss and not taken: no change; no allocation.
- Read-during-write: if fetch and update hit the same index in one cycle, the prediction uses pre-update contents; the new contents are visible from the next cycle.
- Mispredict logic, combinational and gated by upd_valid:
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc + 4.
  - redirect_pc is don't-care when mispredict=0, but must still be driven by the same formula.
- Statistics:
  - branch_count increments on each cycle with upd_valid=1.
  - mispredict_count increments when mispredict=1.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous):
  - All valid bits cleared, all cnt set to 1, both statistics counters cleared.
  - Tag and target arrays need no reset.
  - Reset wins over a simultaneous update.
  - Outputs during and after reset: pred_taken=0, pred_target=fetch_pc+4, counters 0.
  - mispredict and redirect_pc remain combinational from inputs.
- Reset mid-operation discards all training; the next update behaves as a cold miss.

Test Plan:
- After reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104, both statistics counters 0.
- Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle fetch_pc=0x100 -> pred_taken=1, pred_target=0x80. mispredict_count=1.
- Train 0x100 taken 3 times (cnt=3), then not-taken once -> still predicts taken (cnt=2); second not-taken -> pred_taken=0 (cnt=1). Counter saturates at 3 after further taken updates.
- Alias case, IDX_BITS=4: allocate 0x100 taken, then taken update at 0x140 (same index, new tag) -> 0x100 misses (pred_target=0x104) and 0x140 hits.
- Same-cycle fetch_pc=0x200 and first taken update at 0x200 -> that cycle pred_taken=0; next cycle pred_taken=1. Target-change case: upd_taken=1, upd_pred_taken=1, pred_target=0x300, actual 0x340 -> mispredict=1, redirect_pc=0x340.
- Assert rst in the same cycle as a taken update at 0x100 -> entry not allocated; 0x100 predicts not taken; branch_count=0. A not-taken update at 0x180 with pred_taken=1 -> redirect_pc=0x184.
